collision_monitor: RTL and testbench

COLLISION_MONITOR -- requirements
Module: collision_monitor

---
 rtl/collision_monitor_if.sv | 43 ++++
 rtl/collision_monitor.sv | 141 ++++++++++++++
 tb/tb_collision_monitor.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_monitor_if.sv
// collision_monitor_if
//   Groups the scan-control, item and result/statistics signals of
//   collision_monitor into one bundle.
//   master : drives iStart/iStop/iStopOnHit/iTarget/iValid/iData/iNonce,
//            observes every o* signal (testbench or upstream controller).
//   slave  : the monitor itself.
interface collision_monitor_if #(
    parameter int DATA_W  = 160,
    parameter int TGT_W   = 5,
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 16
);
    logic               iStart;
    logic               iStop;
    logic               iStopOnHit;
    logic [TGT_W-1:0]   iTarget;
    logic               iValid;
    logic [DATA_W-1:0]  iData;
    logic [NONCE_W-1:0] iNonce;

    logic               oBusy;
    logic               oResultValid;
    logic               oResult;
    logic [TGT_W:0]     oLeadZeros;
    logic               oFound;
    logic [NONCE_W-1:0] oHitNonce;
    logic [CNT_W-1:0]   oHitCount;
    logic [TGT_W:0]     oBestZeros;
    logic [NONCE_W-1:0] oBestNonce;
    logic               oDone;

    modport master (
        output iStart, iStop, iStopOnHit, iTarget, iValid, iData, iNonce,
        input  oBusy, oResultValid, oResult, oLeadZeros, oFound, oHitNonce,
               oHitCount, oBestZeros, oBestNonce, oDone
    );

    modport slave (
        input  iStart, iStop, iStopOnHit, iTarget, iValid, iData, iNonce,
        output oBusy, oResultValid, oResult, oLeadZeros, oFound, oHitNonce,
               oHitCount, oBestZeros, oBestNonce, oDone
    );
endinterface

// File: rtl/collision_monitor.sv
// collision_monitor
//   Two-stage pipeline that counts leading zeros in the top CHECK_W bits of
//   each digest, flags items meeting the latched target (iTarget+1 zeros),
//   and keeps per-scan statistics: first-hit nonce, hit count, best count.
//   Ports:
//     iClk - clock, all state on rising edge
//     iRst - asynchronous active-high reset
//     bus  - collision_monitor_if.slave (scan control, item in, results out)
module collision_monitor #(
    parameter int DATA_W  = 160,
    parameter int CHECK_W = 32,
    parameter int TGT_W   = 5,
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 16
) (
    input logic                iClk,
    input logic                iRst,
    collision_monitor_if.slave bus
);
    localparam int STAGES = 2;
    localparam int LZ_W   = TGT_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, nextState;

    logic [TGT_W-1:0]   tgtQ;
    logic               stopOnHitQ;
    logic [STAGES:1]    vldPipe;
    logic [LZ_W-1:0]    lzS1;
    logic [NONCE_W-1:0] nonceS1;
    logic [LZ_W-1:0]    lzS2;
    logic               resS2;
    logic               found;
    logic [NONCE_W-1:0] hitNonce;
    logic [CNT_W-1:0]   hitCount;
    logic [LZ_W-1:0]    bestZeros;
    logic [NONCE_W-1:0] bestNonce;

    logic               accept;
    logic               hitNext;
    logic               haltOnHit;
    logic [LZ_W-1:0]    need;

    // Leading-zero count; an all-zero window saturates at CHECK_W.
    function automatic logic [LZ_W-1:0] lzc(input logic [CHECK_W-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(CHECK_W);
        for (int i = 0; i < CHECK_W; i++)
            if (v[i]) n = LZ_W'(CHECK_W - 1 - i);
        return n;
    endfunction

    generate
        if (DATA_W > CHECK_W) begin : gUnusedLow
            logic unusedLowBits;
            assign unusedLowBits = ^bus.iData[DATA_W-CHECK_W-1:0];
        end
    endgenerate

    assign need      = {1'b0, tgtQ} + LZ_W'(1);
    // hitNext: the item leaving stage 1 at this edge qualifies.
    assign hitNext   = lzS1 >= need;
    assign accept    = (state == SCAN) && bus.iValid && !bus.iStart && !bus.iStop;
    // Stop-on-hit halts at the edge the hit lands in stage 2, so whatever
    // enters stage 1 at that edge must be discarded.
    assign haltOnHit = (state == SCAN) && stopOnHitQ && vldPipe[1] && hitNext;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (bus.iStart)
            nextState = SCAN;
        else if ((state == SCAN) && (bus.iStop || haltOnHit))
            nextState = DONE;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            tgtQ       <= '0;
            stopOnHitQ <= 1'b0;
            vldPipe    <= '0;
            lzS1       <= '0;
            nonceS1    <= '0;
            lzS2       <= '0;
            resS2      <= 1'b0;
            found      <= 1'b0;
            hitNonce   <= '0;
            hitCount   <= '0;
            bestZeros  <= '0;
            bestNonce  <= '0;
        end else begin
            // Data registers load every cycle; vldPipe qualifies them.
            lzS1    <= lzc(bus.iData[DATA_W-1 -: CHECK_W]);
            nonceS1 <= bus.iNonce;
            lzS2    <= lzS1;
            resS2   <= hitNext;
            if (bus.iStart) begin
                tgtQ       <= bus.iTarget;
                stopOnHitQ <= bus.iStopOnHit;
                vldPipe    <= '0;
                found      <= 1'b0;
                hitNonce   <= '0;
                hitCount   <= '0;
                bestZeros  <= '0;
                bestNonce  <= '0;
            end else begin
                vldPipe[1] <= accept && !haltOnHit;
                vldPipe[2] <= vldPipe[1];
                if (vldPipe[1]) begin
                    if (hitNext) begin
                        if (hitCount != '1) hitCount <= hitCount + CNT_W'(1);
                        if (!found) begin
                            found    <= 1'b1;
                            hitNonce <= nonceS1;
                        end
                    end
                    // Strict compare: ties keep the earlier nonce.
                    if (lzS1 > bestZeros) begin
                        bestZeros <= lzS1;
                        bestNonce <= nonceS1;
                    end
                end
            end
        end
    end

    assign bus.oBusy        = (state == SCAN);
    assign bus.oDone        = (state == DONE);
    assign bus.oResultValid = vldPipe[2];
    assign bus.oResult      = resS2;
    assign bus.oLeadZeros   = lzS2;
    assign bus.oFound       = found;
    assign bus.oHitNonce    = hitNonce;
    assign bus.oHitCount    = hitCount;
    assign bus.oBestZeros   = bestZeros;
    assign bus.oBestNonce   = bestNonce;
endmodule

// File: tb/tb_collision_monitor.sv
// tb_collision_monitor
//   Directed scenarios plus a randomized run against an item-level model
//   of the collision monitor.
module tb_collision_monitor;
    localparam int DATA_W  = 160;
    localparam int TGT_W   = 5;
    localparam int NONCE_W = 32;
    localparam int CNT_W   = 16;
    localparam int LZ_W    = TGT_W + 1;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    int checks = 0;
    int errors = 0;

    collision_monitor_if bus ();
    collision_monitor dut (.iClk(iClk), .iRst(iRst), .bus(bus));

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mkData(input logic [31:0] msb);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        d[DATA_W-1 -: 32] = msb;
        return d;
    endfunction

    function automatic logic [31:0] msbWithLz(input int lz);
        logic [31:0] top;
        logic [31:0] m;
        if (lz >= 32) return 32'h0;
        top = 32'h8000_0000 >> lz;
        m = $urandom;
        return top | (m & (top - 32'd1));
    endfunction

    function automatic int lzRef(input logic [31:0] msb);
        int n;
        n = 0;
        while (n < 32 && msb[31-n] == 1'b0) n++;
        return n;
    endfunction

    task automatic idle();
        bus.iStart = 1'b0; bus.iStop = 1'b0; bus.iStopOnHit = 1'b0;
        bus.iTarget = '0; bus.iValid = 1'b0; bus.iData = '0; bus.iNonce = '0;
    endtask

    task automatic drive(input logic v, input logic [31:0] msb, input logic [31:0] nonce);
        bus.iValid = v;
        bus.iData  = mkData(msb);
        bus.iNonce = nonce;
    endtask

    task automatic startScan(input int tgt, input logic soh);
        bus.iStart = 1'b1;
        bus.iTarget = TGT_W'(tgt);
        bus.iStopOnHit = soh;
        tick();
        bus.iStart = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        iRst = 1'b1;
        #2;
        checks++;
        if ({bus.oBusy, bus.oDone, bus.oResultValid, bus.oResult, bus.oFound} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000",
                {bus.oBusy, bus.oDone, bus.oResultValid, bus.oResult, bus.oFound});
        end
        checks++;
        if ({bus.oLeadZeros, bus.oHitCount, bus.oHitNonce, bus.oBestZeros, bus.oBestNonce} !== '0) begin
            errors++; $display("FAIL reset_stats got lz=%0d cnt=%0d hn=%0h bz=%0d bn=%0h want all 0",
                bus.oLeadZeros, bus.oHitCount, bus.oHitNonce, bus.oBestZeros, bus.oBestNonce);
        end
        @(negedge iClk) iRst = 1'b0;
        tick();
        checks++;
        if ({bus.oBusy, bus.oDone} !== 2'b00) begin
            errors++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus.oBusy, bus.oDone);
        end
    endtask

    task automatic test_basic();
        startScan(7, 1'b0);
        checks++;
        if (bus.oBusy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bus.oBusy); end
        drive(1'b1, 32'h00FF_FFFF, 32'd100); tick();
        drive(1'b1, 32'h01FF_FFFF, 32'd101); tick();
        checks++;
        if ({bus.oResultValid, bus.oResult, bus.oLeadZeros} !== {1'b1, 1'b1, LZ_W'(8)}) begin
            errors++; $display("FAIL basic_item1 got v=%b r=%b lz=%0d want 1 1 8",
                bus.oResultValid, bus.oResult, bus.oLeadZeros);
        end
        drive(1'b0, 32'h0, 32'd0); tick();
        checks++;
        if ({bus.oResultValid, bus.oResult, bus.oLeadZeros} !== {1'b1, 1'b0, LZ_W'(7)}) begin
            errors++; $display("FAIL basic_item2 got v=%b r=%b lz=%0d want 1 0 7",
                bus.oResultValid, bus.oResult, bus.oLeadZeros);
        end
        tick();
        checks++;
        if ({bus.oResultValid, bus.oHitCount, bus.oFound, bus.oHitNonce} !== {1'b0, CNT_W'(1), 1'b1, 32'd100}) begin
            errors++; $display("FAIL basic_stats got v=%b cnt=%0d f=%b hn=%0d want 0 1 1 100",
                bus.oResultValid, bus.oHitCount, bus.oFound, bus.oHitNonce);
        end
    endtask

    task automatic test_stop_on_hit();
        startScan(3, 1'b1);
        drive(1'b1, 32'h8123_4567, 32'd201); tick();
        drive(1'b1, 32'h0F12_3456, 32'd202); tick();
        checks++;
        if ({bus.oResultValid, bus.oResult, bus.oLeadZeros} !== {1'b1, 1'b0, LZ_W'(0)}) begin
            errors++; $display("FAIL soh_item1 got v=%b r=%b lz=%0d want 1 0 0",
                bus.oResultValid, bus.oResult, bus.oLeadZeros);
        end
        drive(1'b1, 32'h0012_3456, 32'd203); tick();
        checks++;
        if ({bus.oResultValid, bus.oResult, bus.oLeadZeros, bus.oDone, bus.oBusy} !== {1'b1, 1'b1, LZ_W'(4), 1'b1, 1'b0}) begin
            errors++; $display("FAIL soh_item2 got v=%b r=%b lz=%0d done=%b busy=%b want 1 1 4 1 0",
                bus.oResultValid, bus.oResult, bus.oLeadZeros, bus.oDone, bus.oBusy);
        end
        checks++;
        if ({bus.oHitNonce, bus.oHitCount} !== {32'd202, CNT_W'(1)}) begin
            errors++; $display("FAIL soh_hit got hn=%0d cnt=%0d want 202 1", bus.oHitNonce, bus.oHitCount);
        end
        drive(1'b1, 32'hFF00_0000, 32'd204); tick();
        checks++;
        if (bus.oResultValid !== 1'b0) begin errors++; $display("FAIL soh_drop3 got v=%b want 0", bus.oResultValid); end
        drive(1'b0, 32'h0, 32'd0); bus.iStop = 1'b1; tick();
        bus.iStop = 1'b0;
        checks++;
        if ({bus.oResultValid, bus.oDone, bus.oHitCount} !== {1'b0, 1'b1, CNT_W'(1)}) begin
            errors++; $display("FAIL soh_hold got v=%b done=%b cnt=%0d want 0 1 1",
                bus.oResultValid, bus.oDone, bus.oHitCount);
        end
    endtask

    task automatic test_boundary();
        startScan(31, 1'b0);
        drive(1'b1, 32'h0, 32'd301); tick();
        drive(1'b0, 32'h0, 32'd0); tick();
        checks++;
        if ({bus.oResultValid, bus.oResult, bus.oLeadZeros} !== {1'b1, 1'b1, LZ_W'(32)}) begin
            errors++; $display("FAIL bound_t31 got v=%b r=%b lz=%0d want 1 1 32",
                bus.oResultValid, bus.oResult, bus.oLeadZeros);
        end
        startScan(0, 1'b0);
        drive(1'b1, 32'h8000_0000, 32'd302); tick();
        drive(1'b1, 32'h4000_0000, 32'd303); tick();
        checks++;
        if ({bus.oResultValid, bus.oResult, bus.oLeadZeros} !== {1'b1, 1'b0, LZ_W'(0)}) begin
            errors++; $display("FAIL bound_t0_msb1 got v=%b r=%b lz=%0d want 1 0 0",
                bus.oResultValid, bus.oResult, bus.oLeadZeros);
        end
        drive(1'b0, 32'h0, 32'd0); tick();
        checks++;
        if ({bus.oResultValid, bus.oResult, bus.oLeadZeros} !== {1'b1, 1'b1, LZ_W'(1)}) begin
            errors++; $display("FAIL bound_t0_lz1 got v=%b r=%b lz=%0d want 1 1 1",
                bus.oResultValid, bus.oResult, bus.oLeadZeros);
        end
    endtask

    task automatic test_best();
        int lzs[4] = '{3, 5, 5, 2};
        startScan(2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, msbWithLz(lzs[i]), 32'(401 + i)); tick();
        end
        drive(1'b0, 32'h0, 32'd0); tick(); tick();
        checks++;
        if ({bus.oBestZeros, bus.oBestNonce} !== {LZ_W'(5), 32'd402}) begin
            errors++; $display("FAIL best got bz=%0d bn=%0d want 5 402", bus.oBestZeros, bus.oBestNonce);
        end
        checks++;
        if ({bus.oHitCount, bus.oHitNonce} !== {CNT_W'(3), 32'd401}) begin
            errors++; $display("FAIL best_hits got cnt=%0d hn=%0d want 3 401", bus.oHitCount, bus.oHitNonce);
        end
    endtask

    task automatic test_restart_abort();
        startScan(0, 1'b0);
        drive(1'b1, msbWithLz(4), 32'd501); tick();
        drive(1'b1, msbWithLz(6), 32'd502); tick();
        checks++;
        if ({bus.oResultValid, bus.oHitCount} !== {1'b1, CNT_W'(1)}) begin
            errors++; $display("FAIL restart_pre got v=%b cnt=%0d want 1 1", bus.oResultValid, bus.oHitCount);
        end
        bus.iStart = 1'b1; bus.iTarget = '0; bus.iStopOnHit = 1'b0;
        drive(1'b1, msbWithLz(3), 32'd503); tick();
        bus.iStart = 1'b0;
        checks++;
        if ({bus.oResultValid, bus.oHitCount, bus.oFound, bus.oBestZeros, bus.oBestNonce, bus.oBusy}
                !== {1'b0, CNT_W'(0), 1'b0, LZ_W'(0), 32'd0, 1'b1}) begin
            errors++; $display("FAIL restart_clear got v=%b cnt=%0d f=%b bz=%0d bn=%0d busy=%b want 0 0 0 0 0 1",
                bus.oResultValid, bus.oHitCount, bus.oFound, bus.oBestZeros, bus.oBestNonce, bus.oBusy);
        end
        drive(1'b0, 32'h0, 32'd0); tick();
        checks++;
        if ({bus.oResultValid, bus.oHitCount} !== {1'b0, CNT_W'(0)}) begin
            errors++; $display("FAIL restart_inflight got v=%b cnt=%0d want 0 0", bus.oResultValid, bus.oHitCount);
        end
        drive(1'b1, msbWithLz(2), 32'd511); tick();
        bus.iStop = 1'b1;
        drive(1'b1, msbWithLz(9), 32'd512); tick();
        bus.iStop = 1'b0;
        checks++;
        if ({bus.oResultValid, bus.oLeadZeros, bus.oDone, bus.oBusy, bus.oHitNonce}
                !== {1'b1, LZ_W'(2), 1'b1, 1'b0, 32'd511}) begin
            errors++; $display("FAIL abort_complete got v=%b lz=%0d done=%b busy=%b hn=%0d want 1 2 1 0 511",
                bus.oResultValid, bus.oLeadZeros, bus.oDone, bus.oBusy, bus.oHitNonce);
        end
        drive(1'b0, 32'h0, 32'd0); tick();
        checks++;
        if ({bus.oResultValid, bus.oHitCount, bus.oBestZeros} !== {1'b0, CNT_W'(1), LZ_W'(2)}) begin
            errors++; $display("FAIL abort_drop got v=%b cnt=%0d bz=%0d want 0 1 2",
                bus.oResultValid, bus.oHitCount, bus.oBestZeros);
        end
    endtask

    task automatic test_async_reset();
        startScan(0, 1'b0);
        drive(1'b1, msbWithLz(5), 32'd601); tick();
        drive(1'b1, msbWithLz(7), 32'd602); tick();
        #2 iRst = 1'b1;
        #1;
        checks++;
        if ({bus.oBusy, bus.oDone, bus.oResultValid, bus.oResult, bus.oFound} !== 5'b0) begin
            errors++; $display("FAIL arst_flags got %b want 00000",
                {bus.oBusy, bus.oDone, bus.oResultValid, bus.oResult, bus.oFound});
        end
        checks++;
        if ({bus.oLeadZeros, bus.oHitCount, bus.oHitNonce, bus.oBestZeros, bus.oBestNonce} !== '0) begin
            errors++; $display("FAIL arst_stats got lz=%0d cnt=%0d hn=%0h bz=%0d bn=%0h want all 0",
                bus.oLeadZeros, bus.oHitCount, bus.oHitNonce, bus.oBestZeros, bus.oBestNonce);
        end
        tick();
        drive(1'b0, 32'h0, 32'd0);
        @(negedge iClk) iRst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.oResultValid, bus.oBusy} !== 2'b00) begin
                errors++; $display("FAIL arst_release%0d got v=%b busy=%b want 0 0", i, bus.oResultValid, bus.oBusy);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 6; s++) begin
            int tgt, lz, pLz, hits, bestZ;
            logic soh, v, acc, stopped, pV, found, expRes;
            logic [31:0] nonce, pN, hitN, bestN;
            tgt = $urandom_range(0, 31);
            soh = 1'($urandom_range(0, 1));
            startScan(tgt, soh);
            stopped = 1'b0; pV = 1'b0; pLz = 0; pN = '0;
            found = 1'b0; hits = 0; hitN = '0; bestZ = 0; bestN = '0;
            for (int c = 0; c < 31; c++) begin
                logic last;
                last = (c == 30);
                v = ($urandom_range(0, 3) != 0);
                lz = $urandom_range(0, 32);
                nonce = $urandom;
                bus.iStop = last;
                drive(v, msbWithLz(lz), nonce);
                tick();
                acc = v && !stopped && !last;
                expRes = (pLz >= tgt + 1);
                checks++;
                if (bus.oResultValid !== pV) begin
                    errors++; $display("FAIL rand_valid s%0d c%0d got %b want %b", s, c, bus.oResultValid, pV);
                end
                if (pV) begin
                    checks++;
                    if ({bus.oResult, bus.oLeadZeros} !== {expRes, LZ_W'(pLz)}) begin
                        errors++; $display("FAIL rand_item s%0d c%0d got r=%b lz=%0d want %b %0d",
                            s, c, bus.oResult, bus.oLeadZeros, expRes, pLz);
                    end
                    if (expRes) begin
                        hits++;
                        if (!found) begin found = 1'b1; hitN = pN; end
                        if (soh) begin stopped = 1'b1; acc = 1'b0; end
                    end
                    if (pLz > bestZ) begin bestZ = pLz; bestN = pN; end
                end
                if (last) stopped = 1'b1;
                checks++;
                if (bus.oBusy !== !stopped) begin
                    errors++; $display("FAIL rand_busy s%0d c%0d got %b want %b", s, c, bus.oBusy, !stopped);
                end
                pV = acc; pLz = lz; pN = nonce;
            end
            bus.iStop = 1'b0;
            drive(1'b0, 32'h0, 32'd0);
            tick();
            checks++;
            if ({bus.oResultValid, bus.oDone, bus.oHitCount, bus.oFound, bus.oHitNonce}
                    !== {1'b0, 1'b1, CNT_W'(hits), found, hitN}) begin
                errors++; $display("FAIL rand_hits s%0d got v=%b done=%b cnt=%0d f=%b hn=%0h want 0 1 %0d %b %0h",
                    s, bus.oResultValid, bus.oDone, bus.oHitCount, bus.oFound, bus.oHitNonce, hits, found, hitN);
            end
            checks++;
            if ({bus.oBestZeros, bus.oBestNonce} !== {LZ_W'(bestZ), bestN}) begin
                errors++; $display("FAIL rand_best s%0d got bz=%0d bn=%0h want %0d %0h",
                    s, bus.oBestZeros, bus.oBestNonce, bestZ, bestN);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stop_on_hit();
        test_boundary();
        test_best();
        test_restart_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
